// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and encodings for the ARM32 multi-cycle control
//               FSM. Holds the FSM state enum, the instruction-class enum
//               produced by opclass_decode, and the pc_sel / rf_wsel
//               encodings driven to the datapath.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_SHIFT_RS = 4'd2,
        S_EXEC     = 4'd3,
        S_DATA_WB  = 4'd4,
        S_MEM      = 4'd5,
        S_LOAD_WB  = 4'd6,
        S_BASE_WB  = 4'd7,
        S_BRANCH   = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        OC_NOP     = 4'd0,
        OC_HALT    = 4'd1,
        OC_DATA    = 4'd2,
        OC_DATA_RS = 4'd3,
        OC_BRANCH  = 4'd4,
        OC_LDR_LIT = 4'd5,
        OC_LOAD    = 4'd6,
        OC_STORE   = 4'd7,
        OC_ILLEGAL = 4'd8
    } opclass_t;

    // PC source select
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;  // PC + 8 + imm_branch

    // Register-file write source select
    localparam logic [1:0] RF_WSEL_ALU   = 2'b00;  // C -> rd
    localparam logic [1:0] RF_WSEL_MEM   = 2'b01;  // mem rdata -> rd
    localparam logic [1:0] RF_WSEL_BASE  = 2'b10;  // C (base address) -> rn

    // ALU sub-op that only updates flags (no rd writeback)
    localparam logic [2:0] CMP_OP_DEFAULT = 3'b010;

    function automatic logic is_data_class(input opclass_t oc);
        return (oc == OC_DATA) || (oc == OC_DATA_RS);
    endfunction

    // Literal loads go through the same memory read path as ordinary loads
    function automatic logic is_load_class(input opclass_t oc);
        return (oc == OC_LOAD) || (oc == OC_LDR_LIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_controller_opclass_decode.sv
`default_nettype none
// ============================================================================
// Module      : opclass_decode
// Description : Combinational classifier turning the idecoder's 7-bit opcode
//               into an instruction class, plus the base-writeback flag for
//               load/store addressing modes.
// Ports       : opcode_i   in  7  idecoder opcode
//               opclass_o  out    instruction class (opclass_t)
//               wb_base_o  out 1  base register is written back (W | ~P)
// Revision    : 1.0 - initial release
// ============================================================================
module opclass_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output opclass_t   opclass_o,
    output logic       wb_base_o
);

    // Load/store layout is 11_S_R_PUW: P = bit 2, W = bit 0.
    // Post-indexed (P=0) always updates the base; pre-indexed only with W.
    assign wb_base_o = opcode_i[0] | ~opcode_i[2];

    always_comb begin
        opclass_o = OC_ILLEGAL;
        casez (opcode_i)
            7'b0000000: opclass_o = OC_NOP;
            7'b0000001: opclass_o = OC_HALT;
            7'b0001???: opclass_o = OC_DATA;      // immediate operand
            7'b0011???: opclass_o = OC_DATA;      // register operand
            7'b0111???: opclass_o = OC_DATA_RS;   // register shifted by register
            7'b1000???: opclass_o = OC_BRANCH;
            7'b1001111: opclass_o = OC_LDR_LIT;
            7'b110????: opclass_o = OC_LOAD;
            7'b111????: opclass_o = OC_STORE;
            default:    opclass_o = OC_ILLEGAL;   // includes data form [5:4]=10
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Multi-cycle control FSM for the ARM32 core. Sequences fetch,
//               decode, optional shift-amount read, ALU, memory and
//               writeback for one instruction at a time and drives every
//               datapath enable.
// Ports       : clk            in  1  core clock
//               rst_n          in  1  asynchronous active-low reset
//               opcode_i       in  7  idecoder opcode (valid in DECODE)
//               cond_pass_i    in  1  condition satisfied (sampled in DECODE)
//               en_status_i    in  1  S-bit, qualifies status_we_o
//               waitrequest_i  in  1  memory stall (FETCH/MEM only)
//               mem_rd_o       out 1  memory read request
//               mem_wr_o       out 1  memory write request
//               addr_sel_o     out 1  0: PC, 1: address register
//               ir_load_o      out 1  latch rdata into IR
//               pc_en_o        out 1  update PC
//               pc_sel_o       out 2  PC source select
//               load_ab_o      out 1  latch operand regs A/B
//               load_s_o       out 1  latch shift-amount reg
//               alu_en_o       out 1  latch ALU result into C
//               status_we_o    out 1  write NZCV
//               rf_we_o        out 1  register-file write
//               rf_wsel_o      out 2  register-file write source
//               halted_o       out 1  core stopped
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller
    import ctrl_pkg::*;
#(
    parameter logic [2:0] CMP_OP = CMP_OP_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic       cond_pass_i,
    input  logic       en_status_i,
    input  logic       waitrequest_i,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       addr_sel_o,
    output logic       ir_load_o,
    output logic       pc_en_o,
    output logic [1:0] pc_sel_o,
    output logic       load_ab_o,
    output logic       load_s_o,
    output logic       alu_en_o,
    output logic       status_we_o,
    output logic       rf_we_o,
    output logic [1:0] rf_wsel_o,
    output logic       halted_o
);

    state_t   state_q, state_d;
    opclass_t opclass_live;
    logic     wb_base_live;

    // Copies of the decoded instruction captured in DECODE; later states
    // must not look at the live opcode, which the idecoder may already
    // have moved on from.
    opclass_t opclass_q;
    logic     wb_base_q;
    logic [2:0] alu_op_q;

    // run_q is cleared asynchronously by reset and set on the first clock
    // after release. While it is low every output is forced to 0, so a
    // reset in the middle of a transfer drops mem_rd/mem_wr at once and the
    // first fetch request only appears after the first clock edge.
    logic run_q;

    logic decode_cycle;

    opclass_decode u_opclass_decode (
        .opcode_i  (opcode_i),
        .opclass_o (opclass_live),
        .wb_base_o (wb_base_live)
    );

    assign decode_cycle = run_q && (state_q == S_DECODE);

    // ------------------------------------------------------------------
    // State and instruction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            state_q   <= S_FETCH;
            opclass_q <= OC_NOP;
            wb_base_q <= 1'b0;
            alu_op_q  <= 3'b000;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (decode_cycle) begin
                opclass_q <= opclass_live;
                wb_base_q <= wb_base_live;
                alu_op_q  <= opcode_i[2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_load_o   = 1'b0;
        pc_en_o     = 1'b0;
        pc_sel_o    = PC_SEL_SEQ;
        load_ab_o   = 1'b0;
        load_s_o    = 1'b0;
        alu_en_o    = 1'b0;
        status_we_o = 1'b0;
        rf_we_o     = 1'b0;
        rf_wsel_o   = RF_WSEL_ALU;
        halted_o    = 1'b0;

        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd_o   = 1'b1;
                    addr_sel_o = 1'b0;
                    // IR latch and PC+4 happen in the completing cycle
                    if (!waitrequest_i) begin
                        ir_load_o = 1'b1;
                        pc_en_o   = 1'b1;
                        pc_sel_o  = PC_SEL_SEQ;
                        state_d   = S_DECODE;
                    end
                end

                S_DECODE: begin
                    load_ab_o = 1'b1;
                    if (!cond_pass_i) begin
                        state_d = S_FETCH;
                    end else begin
                        case (opclass_live)
                            OC_HALT:    state_d = S_HALT;
                            OC_DATA_RS: state_d = S_SHIFT_RS;
                            OC_DATA,
                            OC_LOAD,
                            OC_STORE,
                            OC_LDR_LIT: state_d = S_EXEC;
                            OC_BRANCH:  state_d = S_BRANCH;
                            default:    state_d = S_FETCH;  // NOP / illegal
                        endcase
                    end
                end

                S_SHIFT_RS: begin
                    load_s_o = 1'b1;
                    state_d  = S_EXEC;
                end

                S_EXEC: begin
                    alu_en_o = 1'b1;
                    if (is_data_class(opclass_q)) begin
                        status_we_o = en_status_i;
                        state_d     = S_DATA_WB;
                    end else begin
                        state_d = S_MEM;
                    end
                end

                S_DATA_WB: begin
                    rf_we_o   = (alu_op_q != CMP_OP);
                    rf_wsel_o = RF_WSEL_ALU;
                    state_d   = S_FETCH;
                end

                S_MEM: begin
                    addr_sel_o = 1'b1;
                    if (opclass_q == OC_STORE) begin
                        mem_wr_o = 1'b1;
                    end else begin
                        mem_rd_o = 1'b1;
                    end
                    if (!waitrequest_i) begin
                        if (is_load_class(opclass_q)) begin
                            state_d = S_LOAD_WB;
                        end else if (wb_base_q) begin
                            state_d = S_BASE_WB;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end

                S_LOAD_WB: begin
                    rf_we_o   = 1'b1;
                    rf_wsel_o = RF_WSEL_MEM;
                    // The literal encoding carries P=1,W=1 bits but has no
                    // base register to update.
                    if (wb_base_q && (opclass_q != OC_LDR_LIT)) begin
                        state_d = S_BASE_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end

                S_BASE_WB: begin
                    rf_we_o   = 1'b1;
                    rf_wsel_o = RF_WSEL_BASE;
                    state_d   = S_FETCH;
                end

                S_BRANCH: begin
                    pc_en_o  = 1'b1;
                    pc_sel_o = PC_SEL_BRANCH;
                    state_d  = S_FETCH;
                end

                S_HALT: begin
                    halted_o = 1'b1;
                    state_d  = S_HALT;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Self-checking bench for cpu_controller. Each instruction is
//               expanded from the architectural rules into a list of
//               expected per-cycle output vectors, which are then played
//               against the DUT with randomised don't-care inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       cond_pass;
    logic       en_status;
    logic       waitrequest;
    logic       mem_rd, mem_wr, addr_sel, ir_load, pc_en;
    logic [1:0] pc_sel;
    logic       load_ab, load_s, alu_en, status_we, rf_we;
    logic [1:0] rf_wsel;
    logic       halted;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode_i      (opcode),
        .cond_pass_i   (cond_pass),
        .en_status_i   (en_status),
        .waitrequest_i (waitrequest),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .addr_sel_o    (addr_sel),
        .ir_load_o     (ir_load),
        .pc_en_o       (pc_en),
        .pc_sel_o      (pc_sel),
        .load_ab_o     (load_ab),
        .load_s_o      (load_s),
        .alu_en_o      (alu_en),
        .status_we_o   (status_we),
        .rf_we_o       (rf_we),
        .rf_wsel_o     (rf_wsel),
        .halted_o      (halted)
    );

    // Output vector bit positions
    localparam logic [14:0] O_RD    = 15'h4000;
    localparam logic [14:0] O_WR    = 15'h2000;
    localparam logic [14:0] O_ASEL  = 15'h1000;
    localparam logic [14:0] O_IR    = 15'h0800;
    localparam logic [14:0] O_PCEN  = 15'h0400;
    localparam logic [14:0] O_PCBR  = 15'h0100;  // pc_sel = 01
    localparam logic [14:0] O_LAB   = 15'h0080;
    localparam logic [14:0] O_LS    = 15'h0040;
    localparam logic [14:0] O_ALU   = 15'h0020;
    localparam logic [14:0] O_ST    = 15'h0010;
    localparam logic [14:0] O_RFWE  = 15'h0008;
    localparam logic [14:0] O_WSMEM = 15'h0002;  // rf_wsel = 01
    localparam logic [14:0] O_WSBAS = 15'h0004;  // rf_wsel = 10
    localparam logic [14:0] O_HALT  = 15'h0001;

    logic [14:0] obs;
    assign obs = {mem_rd, mem_wr, addr_sel, ir_load, pc_en, pc_sel,
                  load_ab, load_s, alu_en, status_we, rf_we, rf_wsel, halted};

    // Instruction classes as seen by the reference model
    localparam int C_NOP = 0, C_HALT = 1, C_DATA = 2, C_RS = 3, C_BR = 4,
                   C_LIT = 5, C_LOAD = 6, C_STORE = 7, C_ILL = 8;

    typedef struct {
        logic        wr;   // waitrequest to drive this cycle
        logic        dec;  // decode cycle: present the real opcode/cond
        logic [14:0] exp;
    } step_t;

    step_t steps[$];
    int    n_total = 0;
    int    n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [6:0] op);
        if (op == 7'b0000000)       return C_NOP;
        if (op == 7'b0000001)       return C_HALT;
        if (op == 7'b1001111)       return C_LIT;
        if (op[6:3] == 4'b1000)     return C_BR;
        if (op[6] == 1'b0 && op[3] == 1'b1) begin
            if (op[5:4] == 2'b00 || op[5:4] == 2'b01) return C_DATA;
            if (op[5:4] == 2'b11)   return C_RS;
            return C_ILL;
        end
        if (op[6:5] == 2'b11)       return op[4] ? C_STORE : C_LOAD;
        return C_ILL;
    endfunction

    task automatic push(input logic wr, input logic dec, input logic [14:0] e);
        step_t s;
        s.wr  = wr;
        s.dec = dec;
        s.exp = e;
        steps.push_back(s);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Expand one instruction into its expected cycle-by-cycle outputs
    task automatic build(input logic [6:0] op, input logic cond, input logic en,
                         input int fw, input int mw);
        int          c;
        logic        wb;
        logic [14:0] memv;
        steps.delete();
        for (int i = 0; i < fw; i++) push(1'b1, 1'b0, O_RD);
        push(1'b0, 1'b0, O_RD | O_IR | O_PCEN);
        push(rbit(), 1'b1, O_LAB);
        c  = classify(op);
        wb = op[0] | ~op[2];
        if (!cond || c == C_NOP || c == C_ILL) return;
        if (c == C_HALT) begin
            for (int i = 0; i < 20; i++) push(rbit(), 1'b0, O_HALT);
            return;
        end
        if (c == C_BR) begin
            push(rbit(), 1'b0, O_PCEN | O_PCBR);
            return;
        end
        if (c == C_RS) push(rbit(), 1'b0, O_LS);
        if (c == C_DATA || c == C_RS) begin
            push(rbit(), 1'b0, O_ALU | (en ? O_ST : 15'h0));
            push(rbit(), 1'b0, (op[2:0] == 3'b010) ? 15'h0 : O_RFWE);
            return;
        end
        push(rbit(), 1'b0, O_ALU);
        memv = (c == C_STORE) ? (O_WR | O_ASEL) : (O_RD | O_ASEL);
        for (int i = 0; i < mw; i++) push(1'b1, 1'b0, memv);
        push(1'b0, 1'b0, memv);
        if (c == C_STORE) begin
            if (wb) push(rbit(), 1'b0, O_RFWE | O_WSBAS);
            return;
        end
        push(rbit(), 1'b0, O_RFWE | O_WSMEM);
        if (wb && c != C_LIT) push(rbit(), 1'b0, O_RFWE | O_WSBAS);
    endtask

    task automatic play(input logic [6:0] op, input logic cond, input logic en,
                        input string name, input int limit);
        for (int i = 0; i < steps.size() && i < limit; i++) begin
            @(negedge clk);
            waitrequest = steps[i].wr;
            en_status   = en;
            if (steps[i].dec) begin
                opcode    = op;
                cond_pass = cond;
            end else begin
                opcode    = 7'($urandom);
                cond_pass = rbit();
            end
            #1 check($sformatf("%s_c%0d", name, i), {17'd0, obs}, {17'd0, steps[i].exp});
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic cond, input logic en,
                             input int fw, input int mw, input string name);
        build(op, cond, en, fw, mw);
        play(op, cond, en, name, 1000);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check({name, "_in_rst"}, {17'd0, obs}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check({name, "_release"}, {17'd0, obs}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        logic       cond;
        rst_n       = 1'b0;
        opcode      = 7'd0;
        cond_pass   = 1'b0;
        en_status   = 1'b0;
        waitrequest = 1'b0;

        do_reset("rst0");

        // Fetch timing after reset: mem_rd in cycle 1, refetch in cycle 3
        run_instr(7'b0000000, 1'b1, 1'b0, 0, 0, "nop_a");
        run_instr(7'b0000000, 1'b1, 1'b0, 0, 0, "nop_b");

        run_instr(7'b0111000, 1'b1, 1'b1, 0, 0, "add_rs");
        run_instr(7'b0111010, 1'b1, 1'b1, 1, 0, "cmp_rs");
        run_instr(7'b0011000, 1'b1, 1'b0, 0, 0, "add_reg");
        run_instr(7'b1100101, 1'b1, 1'b0, 2, 3, "ldr_pw");
        run_instr(7'b1110100, 1'b1, 1'b0, 0, 0, "str_imm");
        run_instr(7'b1111011, 1'b1, 1'b0, 0, 1, "str_reg");
        run_instr(7'b1001111, 1'b1, 1'b0, 0, 2, "ldr_lit");
        run_instr(7'b1100000, 1'b1, 1'b0, 0, 0, "ldr_post");
        run_instr(7'b0001000, 1'b0, 1'b1, 0, 0, "cond_fail");
        run_instr(7'b1000000, 1'b1, 1'b0, 1, 0, "branch");
        run_instr(7'b0101000, 1'b1, 1'b1, 0, 0, "illegal");

        for (int k = 0; k < 150; k++) begin
            op = 7'($urandom);
            case ($urandom_range(0, 4))
                0: op = {3'b011, 1'b1, op[2:0]};
                1: op = {2'b11, op[4:0]};
                2: op = {4'b1000, op[2:0]};
                default: ;
            endcase
            if (op == 7'b0000001) op = 7'b0000000;
            cond = ($urandom_range(0, 7) != 0);
            run_instr(op, cond, rbit(), $urandom_range(0, 2), $urandom_range(0, 3),
                      $sformatf("rnd%0d_op%b", k, op));
        end

        // Reset asserted during a stalled load must drop mem_rd without a clock
        build(7'b1100101, 1'b1, 1'b0, 0, 5);
        play(7'b1100101, 1'b1, 1'b0, "mid_mem", 4);
        #1 rst_n = 1'b0;
        #1;
        check("mid_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
        check("mid_mem_asel_drop", {31'd0, addr_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_mem_release", {17'd0, obs}, 32'd0);
        run_instr(7'b0000000, 1'b1, 1'b0, 0, 0, "refetch");

        // HALT is absorbing for 20 cycles, cleared only by reset
        run_instr(7'b0000001, 1'b1, 1'b0, 0, 0, "halt");
        do_reset("rst_halt");
        run_instr(7'b0011001, 1'b1, 1'b1, 0, 0, "post_halt");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
